// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// 32-bit (parameterisable) integer ALU for the scalar datapath, placed between
// register read and writeback. Operands are captured when in_valid is high and
// the result/carry appear one clock later, qualified by a single-cycle
// out_valid. A new operation can be accepted every cycle.
//
// Parameters
//   DATA_WDTH : operand/result width (even, >= 8). Shift amount is taken from
//               the low $clog2(DATA_WDTH) bits of A.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   A/B/ALUC valid this cycle
//   A         in   operand A; shift amount for shifts
//   B         in   operand B; shifted value for shifts and lui
//   ALUC      in   4-bit operation select
//   out_valid out  OUT/CARRY hold a new result (one cycle pulse per op)
//   OUT       out  registered result
//   CARRY     out  registered carry (add) / borrow (sub) flag, 0 otherwise
//   ILLEGAL   out  only when ALU_ILLEGAL_OP_EN is defined: accepted op was the
//                  reserved encoding 4'b1011 (still executes sra)
//
// Build option
//   ALU_ILLEGAL_OP_EN : adds the registered ILLEGAL flag output.
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int DATA_WDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_WDTH-1:0] A,
    input  logic [DATA_WDTH-1:0] B,
    input  logic [3:0]           ALUC,
    output logic                 out_valid,
    output logic [DATA_WDTH-1:0] OUT,
`ifdef ALU_ILLEGAL_OP_EN
    output logic                 CARRY,
    output logic                 ILLEGAL
`else
    output logic                 CARRY
`endif
);

    localparam int SHW  = $clog2(DATA_WDTH);
    localparam int HALF = DATA_WDTH / 2;

    logic [DATA_WDTH:0]   w_sum;
    logic [DATA_WDTH:0]   w_diff;
    logic [SHW-1:0]       w_shamt;
    logic [DATA_WDTH-1:0] w_res;
    logic                 w_carry;
    logic                 w_illegal;

    logic                 r_out_valid;
    logic [DATA_WDTH-1:0] r_out;
    logic                 r_carry;
    logic                 r_illegal;

    // Operation decode and datapath; ALUC[3] only matters for the shift group
    always_comb begin
        // One extra bit on both operands exposes carry-out / borrow in the MSB
        w_sum     = {1'b0, A} + {1'b0, B};
        w_diff    = {1'b0, A} - {1'b0, B};
        w_shamt   = A[SHW-1:0];
        w_res     = {DATA_WDTH{1'b0}};
        w_carry   = 1'b0;
        w_illegal = (ALUC == 4'b1011);
        case (ALUC[2:0])
            3'b000: begin
                w_res   = w_sum[DATA_WDTH-1:0];
                w_carry = w_sum[DATA_WDTH];
            end
            3'b100: begin
                w_res   = w_diff[DATA_WDTH-1:0];
                w_carry = w_diff[DATA_WDTH];
            end
            3'b010: w_res = A ^ B;
            3'b001: w_res = A & B;
            3'b101: w_res = A | B;
            3'b110: w_res = {B[HALF-1:0], {HALF{1'b0}}};
            3'b011: begin
                // 1011 is reserved and deliberately aliases onto sra
                if (ALUC[3]) begin
                    w_res = $signed(B) >>> w_shamt;
                end else begin
                    w_res = B << w_shamt;
                end
            end
            3'b111: begin
                if (ALUC[3]) begin
                    w_res = $signed(B) >>> w_shamt;
                end else begin
                    w_res = B >> w_shamt;
                end
            end
            default: begin
                w_res   = {DATA_WDTH{1'b0}};
                w_carry = 1'b0;
            end
        endcase
    end

    // Result registers: load only on accepted ops so idle-cycle inputs never reach OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= {DATA_WDTH{1'b0}};
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out     <= w_res;
                r_carry   <= w_carry;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign OUT       = r_out;
    assign CARRY     = r_carry;

`ifdef ALU_ILLEGAL_OP_EN
    // Flag follows out_valid semantics: meaningful only alongside a new result
    assign ILLEGAL = r_illegal & r_out_valid;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = r_illegal;
`endif

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Directed self-checking bench for alu_core (DATA_WDTH = 32). Every operation
// is driven at the falling edge and its result is sampled 1 time unit after
// the following rising edge. Expected values are hand-computed constants,
// plus an independent reference function for the back-to-back random run.
// Honours ALU_ILLEGAL_OP_EN to connect and check the ILLEGAL flag.
// -----------------------------------------------------------------------------
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [3:0]  aluc_s;
    logic        out_valid;
    logic [31:0] out_s;
    logic        carry_s;
`ifdef ALU_ILLEGAL_OP_EN
    logic        illegal_s;
`endif

    int n_checks;
    int n_fails;

    alu_core #(.DATA_WDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_s),
        .B         (b_s),
        .ALUC      (aluc_s),
        .out_valid (out_valid),
        .OUT       (out_s),
`ifdef ALU_ILLEGAL_OP_EN
        .CARRY     (carry_s),
        .ILLEGAL   (illegal_s)
`else
        .CARRY     (carry_s)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model written from the opcode table, not from the RTL structure
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic cy);
        logic [63:0] wide;
        int          sh;
        sh  = int'(a[4:0]);
        res = 32'h0;
        cy  = 1'b0;
        if (op[2:0] == 3'b000) begin
            wide = {32'h0, a} + {32'h0, b};
            res  = wide[31:0];
            cy   = wide[32];
        end else if (op[2:0] == 3'b100) begin
            res = a - b;
            cy  = (a < b);
        end else if (op[2:0] == 3'b010) begin
            res = a ^ b;
        end else if (op[2:0] == 3'b001) begin
            res = a & b;
        end else if (op[2:0] == 3'b101) begin
            res = a | b;
        end else if (op[2:0] == 3'b110) begin
            res = b * 32'd65536;
        end else if (op == 4'b0011) begin
            res = b << sh;
        end else if (op == 4'b0111) begin
            res = b >> sh;
        end else begin
            res = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        end
    endfunction

    // Issue one op, then drop in_valid with garbage operands and return after the result edge
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        aluc_s   = op;
        a_s      = a;
        b_s      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_s      = 32'hxxxx_xxxx;
        b_s      = 32'hxxxx_xxxx;
        aluc_s   = 4'bxxxx;
    endtask

    // Check a single result: valid pulse, value, carry
    task automatic check_res(input string tag, input logic [31:0] exp, input logic exp_cy);
        check_eq({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check_eq({tag, ".out"}, out_s, exp);
        check_eq({tag, ".carry"}, {31'h0, carry_s}, {31'h0, exp_cy});
    endtask

    logic [31:0] exp_r;
    logic        exp_cy;
    logic [3:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_s      = 32'h0;
        b_s      = 32'h0;
        aluc_s   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst.out", out_s, 32'h0);
        check_eq("rst.carry", {31'h0, carry_s}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load a non-zero result, then reset mid-stream with in_valid high
        do_op(4'b1000, 32'hFFFF_FFFF, 32'h0000_0002);
        check_res("pre_rst", 32'h0000_0001, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        aluc_s   = 4'b0000;
        a_s      = 32'h1234_5678;
        b_s      = 32'h1111_1111;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.valid", {31'h0, out_valid}, 32'h0);
        check_eq("midrst.out", out_s, 32'h0);
        check_eq("midrst.carry", {31'h0, carry_s}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("midrst.hold_out", out_s, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst.idle_valid", {31'h0, out_valid}, 32'h0);
        do_op(4'b0000, 32'd3, 32'd8);
        check_res("post_rst.add", 32'h0000_000B, 1'b0);

        // Add / sub
        do_op(4'b1000, 32'hFFFF_FFFF, 32'd1);
        check_res("add_wrap", 32'h0, 1'b1);
        do_op(4'b0100, 32'd11, 32'd8);
        check_res("sub", 32'd3, 1'b0);
        do_op(4'b1100, 32'd8, 32'd11);
        check_res("sub_borrow", 32'hFFFF_FFFD, 1'b1);

        // Idle cycle after an op: out_valid drops, OUT held despite X operands
        @(posedge clk);
        #1;
        check_eq("gap.valid", {31'h0, out_valid}, 32'h0);
        check_eq("gap.out_held", out_s, 32'hFFFF_FFFD);
        check_eq("gap.carry_held", {31'h0, carry_s}, 32'h1);

        // Logic / lui
        do_op(4'b0010, 32'd11, 32'd8);
        check_res("xor", 32'h3, 1'b0);
        do_op(4'b1001, 32'd11, 32'd8);
        check_res("and", 32'h8, 1'b0);
        do_op(4'b0101, 32'd11, 32'd8);
        check_res("or", 32'hB, 1'b0);
        do_op(4'b1110, 32'd11, 32'd8);
        check_res("lui", 32'h0008_0000, 1'b0);

        // Shifts, shamt 11 directly and with ignored upper bits (0x2B)
        for (int k = 0; k < 2; k++) begin
            logic [31:0] sa;
            sa = (k == 0) ? 32'd11 : 32'h0000_002B;
            do_op(4'b0011, sa, 32'd8);
            check_res($sformatf("sll%0d", k), 32'h0000_4000, 1'b0);
            do_op(4'b0111, sa, 32'd8);
            check_res($sformatf("srl%0d", k), 32'h0, 1'b0);
            do_op(4'b1111, sa, 32'hFFFF_FFF8);
            check_res($sformatf("sra%0d", k), 32'hFFFF_FFFF, 1'b0);
            do_op(4'b0111, sa, 32'hFFFF_FFF8);
            check_res($sformatf("srl_neg%0d", k), 32'h001F_FFFF, 1'b0);
        end
        do_op(4'b0011, 32'h0000_0020, 32'h1234_5678);
        check_res("sll_zero", 32'h1234_5678, 1'b0);
        do_op(4'b0111, 32'd31, 32'h8000_0000);
        check_res("srl_max", 32'h0000_0001, 1'b0);

        // Reserved encoding executes sra
        do_op(4'b1011, 32'd4, 32'h8000_0000);
        check_res("rsvd_sra", 32'hF800_0000, 1'b0);
`ifdef ALU_ILLEGAL_OP_EN
        check_eq("rsvd.illegal", {31'h0, illegal_s}, 32'h1);
        do_op(4'b1111, 32'd4, 32'h8000_0000);
        check_eq("sra.illegal", {31'h0, illegal_s}, 32'h0);
`endif

        // Back-to-back random ops, in_valid never drops
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op_r     = 4'($urandom_range(0, 15));
            a_r      = 32'($urandom_range(1, 31));
            b_r      = $urandom;
            in_valid = 1'b1;
            aluc_s   = op_r;
            a_s      = a_r;
            b_s      = b_r;
            ref_alu(op_r, a_r, b_r, exp_r, exp_cy);
            @(posedge clk);
            #1;
            check_res($sformatf("b2b%0d_op%0h", i, op_r), exp_r, exp_cy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a_s      = 32'hxxxx_xxxx;
        b_s      = 32'hxxxx_xxxx;
        @(posedge clk);
        #1;
        check_eq("b2b_gap.valid", {31'h0, out_valid}, 32'h0);
        check_eq("b2b_gap.out_held", out_s, exp_r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the scalar datapath.
- Supports add, sub, xor, and, or, lui and three shift types, selected by a 4-bit ALUC opcode.
- Operands are sampled on a valid strobe; result and carry are registered, one cycle latency.
- Sits between the register-read stage and writeback.

Parameters:
- DATA_WDTH, 32, operand/result width. Must be even and ≥8. Shift amount uses the low log2(DATA_WDTH) bits of A.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B/ALUC valid this cycle
- A  input  DATA_WDTH  operand A; shift amount for shifts
- B  input  DATA_WDTH  operand B; shifted value for shifts and lui
- ALUC  input  4  operation select
- out_valid  output  1  OUT/CARRY hold a new result
- OUT  output  DATA_WDTH  registered result
- CARRY  output  1  registered carry/borrow flag

Behaviour:
- Reset: rst_n low asynchronously clears OUT=0, CARRY=0, out_valid=0. Release takes effect synchronously to clk.
- Latency: in_valid=1 at edge N gives OUT/CARRY for that input after edge N, with out_valid=1 for exactly that cycle.
- in_valid=0: out_valid=0 next cycle; OUT/CARRY hold their previous values. No backpressure; a new op can be accepted every cycle.
- ALUC decode (? = don't care):
  - ?000 add: OUT=A+B; CARRY=carry-out of bit W-1.
  - ?100 sub: OUT=A-B mod 2^W; CARRY=1 iff A<B unsigned (borrow).
  - ?010 xor: A^B.
  - ?001 and: A&B.
  - ?101 or: A|B.
  - ?110 lui: OUT={B[W/2-1:0], W/2 zeros}.
  - 0011 sll: B << A[log2W-1:0].
  - 0111 srl: B >> shamt, logical.
  - 1111 sra: B >>> shamt, arithmetic, sign=B[W-1].
  - 1011 (reserved): executes sra, same as 1111.
- CARRY=0 for all ops except add/sub.
- Shift amount: only the low log2(W) bits of A are used; upper bits are ignored. Shift by 0 gives B unchanged.
- Arithmetic wraps modulo 2^W; no overflow flag.
- Reset asserted mid-operation: pending result is discarded; out_valid stays 0 until the first accepted op after release.
- X on inputs while in_valid=0 must not propagate to OUT.

Optional Feature:
- Macro ALU_ILLEGAL_OP_EN.
- Defined: adds output port ILLEGAL (1 bit), registered with the same latency and reset value 0. ILLEGAL=1 with out_valid when the accepted ALUC==4'b1011. OUT still carries the sra result.
- Undefined: no ILLEGAL port; 1011 silently executes sra.

Test Plan:
- Reset: rst_n low mid-stream with in_valid=1 -> OUT=0, CARRY=0, out_valid=0 immediately. After release, first op ALUC=0000 A=3 B=8 -> OUT=0x0000000B, CARRY=0 one cycle later.
- Add/sub: ALUC=1000 A=0xFFFFFFFF B=1 -> OUT=0, CARRY=1. ALUC=0100 A=11 B=8 -> OUT=3, CARRY=0. ALUC=1100 A=8 B=11 -> OUT=0xFFFFFFFD, CARRY=1.
- Logic/lui with A=11 B=8:
  - xor (0010) -> 0x3
  - and (1001) -> 0x8
  - or (0101) -> 0xB
  - lui (1110) -> 0x00080000
  - CARRY=0 for all.
- Shifts with A=11:
  - sll (0011), B=8 -> 0x00004000
  - srl (0111), B=8 -> 0x0
  - sra (1111), B=0xFFFFFFF8 -> 0xFFFFFFFF
  - srl, B=0xFFFFFFF8 -> 0x001FFFFF
  - A=0x2B (upper bits ignored, shamt=11) gives identical results.
- Reserved/feature: ALUC=1011 A=4 B=0x80000000 -> OUT=0xF8000000. ILLEGAL=1 when ALU_ILLEGAL_OP_EN is defined; no ILLEGAL port otherwise.
- Throughput: back-to-back in_valid for 20 random ops (A in 1..31, all ALUC) -> each result appears exactly one cycle later with out_valid=1. A gap in in_valid gives out_valid=0 with OUT held.
